// File: rtl/factorial_pkg.sv
// Shared constants and state encoding for the factorial blocks.
// Widths and the iteration bound are common to calc and inverse.
package factorial_pkg;

    localparam int FACT_W = 32;
    localparam int N_W    = 4;

    localparam logic [N_W-1:0] MAX_N = 4'd12;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LOAD = 4'd1,
        S_CALC = 4'd2,
        S_DONE = 4'd3
    } state_t;

endpackage

// File: rtl/factorial_inverse_mul32x4.sv
// Combinational 32x4 unsigned multiplier, product truncated to 32 bits.
// The running-product bound keeps the truncation lossless in practice.
module mul32x4
    import factorial_pkg::*;
(
    input  logic [FACT_W-1:0] i_a,
    input  logic [N_W-1:0]    i_b,
    output logic [FACT_W-1:0] o_p
);

    logic [FACT_W-1:0] w_b_ext;

    assign w_b_ext = {{(FACT_W-N_W){1'b0}}, i_b};
    assign o_p     = i_a * w_b_ext;

endmodule

// File: rtl/factorial_inverse.sv
// Recovers n from a 32-bit value equal to n! (n in 0..12) by
// iterative multiply-and-compare; GO/DONE handshake, no division.
module factorial_inverse
    import factorial_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              GO,
    input  logic [FACT_W-1:0] value,
    output logic              DONE,
    output logic [N_W-1:0]    n,
    output logic              VALID,
    output logic [3:0]        debugcs
);

    state_t            r_state;
    state_t            w_next;
    logic [FACT_W-1:0] r_v;
    logic [FACT_W-1:0] r_p;
    logic [N_W-1:0]    r_k;
    logic [N_W-1:0]    r_n;
    logic              r_valid;

    logic [FACT_W-1:0] w_v_nx;
    logic [FACT_W-1:0] w_p_nx;
    logic [N_W-1:0]    w_k_nx;
    logic [N_W-1:0]    w_n_nx;
    logic              w_valid_nx;
    logic [N_W-1:0]    w_k1;
    logic [FACT_W-1:0] w_prod;

    assign w_k1 = r_k + 4'd1;

    mul32x4 u_mul (
        .i_a (r_p),
        .i_b (w_k1),
        .o_p (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_v     <= '0;
            r_p     <= 32'd1;
            r_k     <= '0;
            r_n     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_v     <= w_v_nx;
            r_p     <= w_p_nx;
            r_k     <= w_k_nx;
            r_n     <= w_n_nx;
            r_valid <= w_valid_nx;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_v_nx     = r_v;
        w_p_nx     = r_p;
        w_k_nx     = r_k;
        w_n_nx     = r_n;
        w_valid_nx = r_valid;
        unique case (r_state)
            S_IDLE: begin
                if (GO) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_v_nx = value;
                w_p_nx = 32'd1;
                w_k_nx = '0;
                w_next = S_CALC;
            end
            S_CALC: begin
                // Equality wins first, so value 1 resolves to 0! not 1!.
                if (r_p == r_v) begin
                    w_n_nx     = r_k;
                    w_valid_nx = 1'b1;
                    w_next     = S_DONE;
                end else if (r_p > r_v || r_k == MAX_N) begin
                    w_n_nx     = '0;
                    w_valid_nx = 1'b0;
                    w_next     = S_DONE;
                end else begin
                    w_k_nx = w_k1;
                    w_p_nx = w_prod;
                end
            end
            S_DONE: begin
                if (!GO) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign DONE    = (r_state == S_DONE);
    assign n       = r_n;
    assign VALID   = r_valid;
    assign debugcs = r_state;

endmodule
